// File: rtl/tx_packet_pkg.sv
// Shared types and constants for the transmit_packet_1 TX stage.
//   tx_state_t     : top-level FSM states
//   BYTES_PER_WORD : bytes carried by one 32-bit RAM word
//   BE_ALL         : byteenable for a full-word read
package tx_packet_pkg;

    typedef enum logic [2:0] {
        IDLE,
        RD_REQ,
        RD_WAIT,
        SEND,
        DONE
    } tx_state_t;

    localparam int         BYTES_PER_WORD = 4;
    localparam logic [3:0] BE_ALL         = 4'hF;

endpackage

// File: rtl/tx_word_serializer.sv
// Holds one 32-bit RAM word and emits it little-endian, one byte per
// accepted Avalon-ST beat.
// Ports:
//   clk, rst     : clock, async active-high reset
//   load         : capture word_in / nbytes_in and restart at byte 0
//   word_in      : RAM read data
//   nbytes_in    : valid bytes in this word (1..4)
//   en           : top is in its SEND state
//   rdy          : Avalon-ST ready from the MAC FIFO
//   wren         : Avalon-ST valid
//   data         : selected byte (0 when not enabled)
//   first_idx    : current byte is byte 0 of the word
//   last_byte    : current byte is the last valid byte of the word
//   xfer         : a byte is transferred this cycle
module tx_word_serializer (
    input  logic        clk,
    input  logic        rst,
    input  logic        load,
    input  logic [31:0] word_in,
    input  logic [2:0]  nbytes_in,
    input  logic        en,
    input  logic        rdy,
    output logic        wren,
    output logic [7:0]  data,
    output logic        first_idx,
    output logic        last_byte,
    output logic        xfer
);

    logic [31:0] word_q;
    logic [1:0]  idx_q;
    logic [2:0]  nbytes_q;

    assign wren      = en;
    assign xfer      = en && rdy;
    assign first_idx = (idx_q == 2'd0);
    assign last_byte = ({1'b0, idx_q} == (nbytes_q - 3'd1));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            word_q   <= 32'h0;
            idx_q    <= 2'd0;
            nbytes_q <= 3'd0;
        end else if (load) begin
            word_q   <= word_in;
            nbytes_q <= nbytes_in;
            idx_q    <= 2'd0;
        end else if (xfer) begin
            idx_q <= idx_q + 2'd1;
        end
    end

    // Byte 0 is the least significant byte, matching the receive side.
    always_comb begin
        data = 8'h00;
        if (en) begin
            case (idx_q)
                2'd0: data = word_q[7:0];
                2'd1: data = word_q[15:8];
                2'd2: data = word_q[23:16];
                2'd3: data = word_q[31:24];
                default: data = 8'h00;
            endcase
        end
    end

endmodule

// File: rtl/transmit_packet_1.sv
// TX stage: on start, reads a stored packet from RAM over Avalon-MM
// (32-bit words) and streams it byte-wise to the MAC TX FIFO (Avalon-ST).
// Optional feature macro: TX_PKT_CNT_EN adds tx_pkt_count / tx_byte_count.
// Ports:
//   clk_original, rst            : clock, async active-high reset
//   start, start_addr, pkt_len   : packet request (sampled in IDLE only)
//   busy, done                   : status
//   ram_*                        : Avalon-MM read master
//   ff_tx_*                      : Avalon-ST byte source to the MAC
//   tx_pkt_count, tx_byte_count  : statistics (TX_PKT_CNT_EN only)
module transmit_packet_1
    import tx_packet_pkg::*;
#(
    parameter int ADDR_W = 10,
    parameter int LEN_W  = 12
) (
    input  logic              clk_original,
    input  logic              rst,
    input  logic              start,
    input  logic [ADDR_W-1:0] start_addr,
    input  logic [LEN_W-1:0]  pkt_len,
    output logic              busy,
    output logic              done,
    output logic [ADDR_W-1:0] ram_addr,
    output logic              ram_chipselect,
    output logic              ram_read,
    output logic [3:0]        ram_byteenable,
    input  logic [31:0]       ram_readdata,
    input  logic              ram_waitrequest,
    output logic [7:0]        ff_tx_data,
    output logic              ff_tx_sop,
    output logic              ff_tx_eop,
    output logic              ff_tx_wren,
    output logic              ff_tx_err,
    output logic              ff_tx_crc_fwd,
    input  logic              ff_tx_rdy
`ifdef TX_PKT_CNT_EN
    ,
    output logic [31:0]       tx_pkt_count,
    output logic [31:0]       tx_byte_count
`endif
);

    tx_state_t         state_q, state_d;
    logic [ADDR_W-1:0] addr_q;
    logic [LEN_W-1:0]  remaining_q;
    logic              first_q;

    logic       in_send, ser_xfer, ser_first, ser_last;
    logic [2:0] nbytes;

    assign in_send = (state_q == SEND);
    assign nbytes  = (remaining_q >= LEN_W'(BYTES_PER_WORD)) ? 3'(BYTES_PER_WORD)
                                                              : remaining_q[2:0];

    tx_word_serializer u_ser (
        .clk       (clk_original),
        .rst       (rst),
        .load      (state_q == RD_WAIT),
        .word_in   (ram_readdata),
        .nbytes_in (nbytes),
        .en        (in_send),
        .rdy       (ff_tx_rdy),
        .wren      (ff_tx_wren),
        .data      (ff_tx_data),
        .first_idx (ser_first),
        .last_byte (ser_last),
        .xfer      (ser_xfer)
    );

    always_ff @(posedge clk_original or posedge rst) begin
        if (rst) state_q <= IDLE;
        else     state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (start && pkt_len != '0) state_d = RD_REQ;
            RD_REQ:  if (!ram_waitrequest) state_d = RD_WAIT;
            RD_WAIT: state_d = SEND;
            // remaining_q == 1 on the final transfer means the packet ends here
            SEND:    if (ser_xfer && ser_last)
                         state_d = (remaining_q == LEN_W'(1)) ? DONE : RD_REQ;
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk_original or posedge rst) begin
        if (rst) begin
            addr_q      <= '0;
            remaining_q <= '0;
            first_q     <= 1'b0;
        end else begin
            case (state_q)
                IDLE: if (start && pkt_len != '0) begin
                    addr_q      <= start_addr;
                    remaining_q <= pkt_len;
                    first_q     <= 1'b1;
                end
                // address wraps naturally at 2^ADDR_W
                RD_REQ: if (!ram_waitrequest) addr_q <= addr_q + ADDR_W'(1);
                SEND: if (ser_xfer) begin
                    remaining_q <= remaining_q - LEN_W'(1);
                    first_q     <= 1'b0;
                end
                default: ;
            endcase
        end
    end

    assign busy           = (state_q == RD_REQ) || (state_q == RD_WAIT) || in_send;
    assign done           = (state_q == DONE);
    assign ram_chipselect = (state_q == RD_REQ);
    assign ram_read       = (state_q == RD_REQ);
    assign ram_addr       = (state_q == RD_REQ) ? addr_q : '0;
    assign ram_byteenable = BE_ALL;
    assign ff_tx_sop      = in_send && first_q && ser_first;
    assign ff_tx_eop      = in_send && (remaining_q == LEN_W'(1));
    assign ff_tx_err      = 1'b0;
    assign ff_tx_crc_fwd  = 1'b0;

`ifdef TX_PKT_CNT_EN
    always_ff @(posedge clk_original or posedge rst) begin
        if (rst) begin
            tx_pkt_count  <= 32'h0;
            tx_byte_count <= 32'h0;
        end else begin
            if (state_q == DONE) tx_pkt_count  <= tx_pkt_count + 32'd1;
            if (ser_xfer)        tx_byte_count <= tx_byte_count + 32'd1;
        end
    end
`endif

endmodule
